pwm_audio_out: RTL

PWM_AUDIO_OUT -- requirements
Module: pwm_audio_out

---
 rtl/func_gen_pkg.sv | 23 ++
 rtl/pwm_carrier.sv | 32 +++
 rtl/pwm_audio_out.sv | 107 ++++++++++
 3 files changed

// File: rtl/func_gen_pkg.sv
// Shared types and constants for the function generator's audio output path.
package func_gen_pkg;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN, DRAIN} pwm_state_t;

  localparam logic [7:0] MIDSCALE   = 8'd128;
  localparam logic [7:0] UNITY_GAIN = 8'd255;

  // Unity gain bypasses the multiplier so a full-scale sample stays full-scale.
  function automatic logic [7:0] scale_sample(input logic [7:0] sample,
                                              input logic [7:0] gain,
                                              input logic       mute);
    logic [15:0] product;
    product = 16'(sample) * 16'(gain);
    if (mute)
      return MIDSCALE;
    else if (gain == UNITY_GAIN)
      return sample;
    else
      return product[15:8];
  endfunction

endpackage

// File: rtl/pwm_carrier.sv
// Prescaler plus 8-bit carrier ramp; both sit at zero while hold is high.
module pwm_carrier #(
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  output logic       tick,
  output logic       boundary,
  output logic [7:0] carrier
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic [15:0] prescale_cnt;

  assign tick     = !hold && (prescale_cnt == PRESCALE_LAST);
  assign boundary = tick && (carrier == 8'hFF);

  always_ff @(posedge clk) begin
    if (!rst_n || hold) begin
      prescale_cnt <= '0;
      carrier      <= '0;
    end else if (tick) begin
      prescale_cnt <= '0;
      carrier      <= carrier + 8'd1;
    end else begin
      prescale_cnt <= prescale_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio driver: amplifier power sequencing, per-period duty load and the
// registered bitstream; duty only changes on a carrier period boundary.
module pwm_audio_out
  import func_gen_pkg::*;
#(
  parameter int PRESCALE       = 1,
  parameter int WARMUP_PERIODS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] sample_in,
  input  logic [7:0] gain,
  input  logic       mute,
  output logic       pwm_out,
  output logic       sd_n,
  output logic [7:0] duty,
  output logic       period_start,
  output logic       busy
);

  localparam logic [7:0] WARMUP_LAST = 8'(WARMUP_PERIODS - 1);

  pwm_state_t state;
  logic [7:0] warm_cnt;
  logic [7:0] carrier;
  logic [7:0] next_duty;
  logic       boundary;
  logic       tick_unused;

  // Tick is exported for other consumers; the FSM only needs the boundary.
  pwm_carrier #(.PRESCALE(PRESCALE)) u_carrier (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (state == IDLE),
    .tick     (tick_unused),
    .boundary (boundary),
    .carrier  (carrier)
  );

  assign next_duty = scale_sample(sample_in, gain, mute);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      warm_cnt     <= '0;
      duty         <= '0;
      pwm_out      <= 1'b0;
      sd_n         <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= 1'b0;
      pwm_out      <= ((state == RUN) || (state == DRAIN)) && (carrier < duty);
      case (state)
        IDLE: begin
          warm_cnt <= '0;
          if (enable) begin
            state <= WARMUP;
            sd_n  <= 1'b1;
          end
        end
        WARMUP: begin
          if (boundary) begin
            if (!enable) begin
              state <= IDLE;
              sd_n  <= 1'b0;
              duty  <= '0;
            end else begin
              duty         <= next_duty;
              period_start <= 1'b1;
              if (warm_cnt == WARMUP_LAST)
                state <= RUN;
              else
                warm_cnt <= warm_cnt + 8'd1;
            end
          end
        end
        RUN: begin
          // A boundary that coincides with the enable fall still loads, so
          // the period after it is the one that gets drained.
          if (boundary) begin
            duty         <= next_duty;
            period_start <= 1'b1;
          end
          if (!enable)
            state <= DRAIN;
        end
        DRAIN: begin
          if (boundary) begin
            if (enable) begin
              state        <= RUN;
              duty         <= next_duty;
              period_start <= 1'b1;
            end else begin
              state <= IDLE;
              sd_n  <= 1'b0;
              duty  <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
